// File: rtl/adder_stream_arbiter.sv
// adder_stream_arbiter
// Shares one constant-adder AXI4-Stream input between C_NUM_REQ requesters.
// A requester is chosen round-robin and keeps the grant for a whole packet.
// The granted stream passes through a 2-entry registered skid stage. Each beat
// carries its source index and the constant that was latched at grant time.
//
// Handshake: a beat moves on any port only in a cycle where tvalid and tready
// are both high at the rising edge. A source holds tvalid and its payload
// stable until the beat is taken. s_axis_tready depends only on registered
// state, so it never depends combinationally on m_axis_tready or on any
// tvalid input.
module adder_stream_arbiter #(
    parameter int C_NUM_REQ          = 4,
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_ADDER_BIT_WIDTH  = 32,
    parameter int C_ID_WIDTH         = 2
) (
    input  logic                                        aclk,
    input  logic                                        areset,
    input  logic [C_NUM_REQ-1:0]                        ctrl_enable,
    input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0]      ctrl_constants,
    input  logic [C_NUM_REQ-1:0]                        s_axis_tvalid,
    output logic [C_NUM_REQ-1:0]                        s_axis_tready,
    input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [C_NUM_REQ-1:0]                        s_axis_tlast,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]               m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic                                        m_axis_tlast,
    output logic [C_ID_WIDTH-1:0]                       m_axis_tid,
    output logic [C_ADDER_BIT_WIDTH-1:0]                m_constant,
    output logic                                        status_busy,
    output logic [C_NUM_REQ-1:0]                        status_grant
);

    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int KW = C_AXIS_TDATA_WIDTH / 8;
    localparam int CW = C_ADDER_BIT_WIDTH;
    localparam int IW = C_ID_WIDTH;
    localparam int PW = $clog2(C_NUM_REQ);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [PW-1:0] PTR_RST = PW'(C_NUM_REQ - 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [IW-1:0] tid;
        logic [CW-1:0] cnst;
    } beat_t;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] const_q, const_d;
    logic [IW-1:0] tid_q, tid_d;
    beat_t         slot0_q, slot0_d;
    beat_t         slot1_q, slot1_d;
    logic [1:0]    count_q, count_d;

    logic [C_NUM_REQ-1:0] cand;
    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    int                   cand_idx;
    beat_t                in_beat;
    logic                 in_valid;
    logic                 skid_ready;
    logic                 push;
    logic                 pop;

    assign skid_ready = (count_q != 2'd2);
    assign push       = in_valid && skid_ready;
    assign pop        = (count_q != 2'd0) && m_axis_tready;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        cand       = s_axis_tvalid & ctrl_enable;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = 0;
        for (int i = 1; i <= C_NUM_REQ; i++) begin
            cand_idx = (int'(ptr_q) + i) % C_NUM_REQ;
            if (!pick_found && cand[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(cand_idx);
            end
        end
    end

    // Select the granted requester's beat and tag it with the latched tid/constant.
    always_comb begin
        in_beat.data = s_axis_tdata[int'(grant_q)*DW +: DW];
        in_beat.keep = s_axis_tkeep[int'(grant_q)*KW +: KW];
        in_beat.last = s_axis_tlast[grant_q];
        in_beat.tid  = tid_q;
        in_beat.cnst = const_q;
        in_valid     = (state_q == ST_GRANT) && s_axis_tvalid[grant_q];
    end

    // Only the granted requester sees ready; status mirrors the held grant.
    always_comb begin
        s_axis_tready = '0;
        status_grant  = '0;
        if (state_q == ST_GRANT) begin
            s_axis_tready[grant_q] = skid_ready;
            status_grant[grant_q]  = 1'b1;
        end
    end

    // Arbitration FSM: grant in IDLE, hold until the tlast beat is taken.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        const_d = const_q;
        tid_d   = tid_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    grant_d = pick_idx;
                    ptr_d   = pick_idx;
                    const_d = ctrl_constants[int'(pick_idx)*CW +: CW];
                    tid_d   = IW'(pick_idx);
                end
            end
            default: begin
                if (push && in_beat.last) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    // Two-slot skid stage; slot0 is always the head presented on m_axis.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    slot0_d = in_beat;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    slot0_d = in_beat;
                end else if (push) begin
                    slot1_d = in_beat;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    count_d = 2'd1;
                end
            end
        endcase
    end

    // State registers; async reset empties the skid stage and rewinds the pointer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RST;
            const_q <= '0;
            tid_q   <= '0;
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            const_q <= const_d;
            tid_q   <= tid_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = slot0_q.data;
    assign m_axis_tkeep  = slot0_q.keep;
    assign m_axis_tlast  = slot0_q.last;
    assign m_axis_tid    = slot0_q.tid;
    assign m_constant    = slot0_q.cnst;
    assign status_busy   = (state_q == ST_GRANT);

endmodule

// File: tb/tb_adder_stream_arbiter.sv
// tb_adder_stream_arbiter
// Directed scenarios with random payloads, checked against a packet-level
// round-robin model and a beat-count model of the skid stage.
module tb_adder_stream_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int CW   = 32;
  localparam int IW   = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } sbeat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [IW-1:0] tid;
    logic [CW-1:0] cnst;
  } ebeat_t;

  // DUT signals
  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      en_a;
  logic [NREQ*CW-1:0]   ctrl_constants;
  logic [NREQ-1:0]      s_valid;
  logic [NREQ-1:0]      s_ready;
  logic [NREQ*DW-1:0]   s_data;
  logic [NREQ*KW-1:0]   s_keep;
  logic [NREQ-1:0]      s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [DW-1:0]        m_data;
  logic [KW-1:0]        m_keep;
  logic                 m_last;
  logic [IW-1:0]        m_tid;
  logic [CW-1:0]        m_const;
  logic                 status_busy;
  logic [NREQ-1:0]      status_grant;

  // Bench state
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  sbeat_t        drv_q[NREQ][$];
  sbeat_t        mdl_q[NREQ][$];
  ebeat_t        exp_q[$];
  int            stamp_q[$];
  bit            stamp_en = 0;
  logic [CW-1:0] const_a[NREQ];
  int            acc_cnt[NREQ];
  bit            mid[NREQ];
  logic [NREQ-1:0] fire = '0;
  int            backlog = 0;
  int            mptr = NREQ - 1;
  bit            tog_en = 0;
  bit            rnd_bp = 0;
  bit            rnd_hold = 0;
  logic [3:0]    tog_pat = 4'b1001;

  adder_stream_arbiter #(
    .C_NUM_REQ(NREQ), .C_AXIS_TDATA_WIDTH(DW),
    .C_ADDER_BIT_WIDTH(CW), .C_ID_WIDTH(IW)
  ) dut (
    .aclk(clk), .areset(rst),
    .ctrl_enable(en_a), .ctrl_constants(ctrl_constants),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .m_axis_tid(m_tid), .m_constant(m_const),
    .status_busy(status_busy), .status_grant(status_grant)
  );

  // clock / reset block
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always_comb begin
    ctrl_constants = '0;
    for (int i = 0; i < NREQ; i++) ctrl_constants[i*CW +: CW] = const_a[i];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_packet(input int r, input int len);
    sbeat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.keep = 8'($urandom);
      b.last = (k == len - 1);
      drv_q[r].push_back(b);
      mdl_q[r].push_back(b);
    end
  endtask

  // Packet-level model: repeatedly hand a whole packet to the next enabled
  // requester (after the previous winner) that still has packets queued.
  task automatic predict();
    bit     found;
    int     r;
    int     c;
    sbeat_t b;
    ebeat_t e;
    do begin
      found = 0;
      r = 0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (mptr + k) % NREQ;
        if (!found && en_a[c] && mdl_q[c].size() != 0) begin
          found = 1;
          r = c;
        end
      end
      if (found) begin
        do begin
          b = mdl_q[r].pop_front();
          e.data = b.data;
          e.keep = b.keep;
          e.last = b.last;
          e.tid  = IW'(r);
          e.cnst = const_a[r];
          exp_q.push_back(e);
        end while (!b.last);
        mptr = r;
      end
    end while (found);
  endtask

  function automatic bit pending(input bit with_drv);
    bit p;
    p = (exp_q.size() != 0) || (backlog != 0) || (status_busy === 1'b1);
    if (with_drv)
      for (int i = 0; i < NREQ; i++) if (drv_q[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic wait_drain(input string tag, input int budget, input bit with_drv);
    int n;
    n = 0;
    while (pending(with_drv) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 128'(n < budget), 128'(1));
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input string tag, input int r, input int target, input int budget);
    int n;
    n = 0;
    while (acc_cnt[r] < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(tag, 128'(n < budget), 128'(1));
  endtask

  task automatic flush_bench();
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
      mid[i] = 0;
    end
    fire = '0;
    mptr = NREQ - 1;
  endtask

  // Source driver: retire beats taken at the last edge, present the next head.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (!rst && fire[i] && drv_q[i].size() != 0) begin
        mid[i] = !drv_q[i][0].last;
        void'(drv_q[i].pop_front());
        acc_cnt[i]++;
      end
      if (drv_q[i].size() != 0 && !(rnd_hold && mid[i] && $urandom_range(0, 2) == 0)) begin
        s_valid[i] = 1'b1;
        s_data[i*DW +: DW] = drv_q[i][0].data;
        s_keep[i*KW +: KW] = drv_q[i][0].keep;
        s_last[i] = drv_q[i][0].last;
      end else begin
        s_valid[i] = 1'b0;
      end
    end
    if (tog_en) m_ready = tog_pat[cyc % 4];
    else if (rnd_bp) m_ready = ($urandom_range(0, 3) != 0);
    else m_ready = 1'b1;
  end

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    ebeat_t e;
    if (rst) begin
      fire = '0;
      backlog = 0;
    end else begin
      fire = s_valid & s_ready;
      chk("tready_onehot0", 128'($onehot0(s_ready)), 128'(1));
      chk("grant_onehot0", 128'($onehot0(status_grant)), 128'(1));
      chk("busy_vs_grant", 128'(status_busy), 128'(|status_grant));
      chk("latency_valid", 128'(m_valid), 128'(backlog != 0));
      if (backlog == 2) chk("full_tready", 128'(s_ready), 128'(0));
      if (m_valid && m_ready) begin
        if (stamp_en) stamp_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 128'(m_data), 128'(e.data));
          chk("beat_keep", 128'(m_keep), 128'(e.keep));
          chk("beat_last", 128'(m_last), 128'(e.last));
          chk("beat_tid", 128'(m_tid), 128'(e.tid));
          chk("beat_const", 128'(m_const), 128'(e.cnst));
        end
      end
      backlog = backlog + $countones(fire) - ((m_valid && m_ready) ? 1 : 0);
      chk("backlog_max", 128'(backlog <= 2), 128'(1));
    end
  end

  // directed steps
  initial begin
    int base;
    rst = 1;
    m_ready = 1;
    en_a = '1;
    s_valid = '0;
    s_data = '0;
    s_keep = '0;
    s_last = '0;
    for (int i = 0; i < NREQ; i++) begin
      const_a[i] = $urandom;
      acc_cnt[i] = 0;
      mid[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_m_data", 128'(m_data), 128'(0));
    chk("rst_m_keep", 128'(m_keep), 128'(0));
    chk("rst_m_last", 128'(m_last), 128'(0));
    chk("rst_m_tid", 128'(m_tid), 128'(0));
    chk("rst_m_const", 128'(m_const), 128'(0));
    chk("rst_busy", 128'(status_busy), 128'(0));
    chk("rst_grant", 128'(status_grant), 128'(0));
    chk("rst_tready", 128'(s_ready), 128'(0));
    rst = 0;
    @(posedge clk);
    #2;

    // 1: requesters 0 and 2, 3 beats each, one bubble between packets
    stamp_q.delete();
    stamp_en = 1;
    send_packet(0, 3);
    send_packet(2, 3);
    predict();
    wait_drain("s1_drain", 200, 1);
    stamp_en = 0;
    chk("s1_beats", 128'(stamp_q.size()), 128'(6));
    if (stamp_q.size() == 6)
      for (int k = 0; k < 5; k++)
        chk("s1_gap", 128'(stamp_q[k+1] - stamp_q[k]), 128'((k == 2) ? 2 : 1));

    // 2: all requesters, 2 packets each, constants 1..4
    for (int i = 0; i < NREQ; i++) const_a[i] = CW'(i + 1);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NREQ; i++) send_packet(i, $urandom_range(1, 4));
    predict();
    wait_drain("s2_drain", 400, 1);

    // 3: 8 beats from requester 1 under 1,0,0,1 backpressure
    tog_en = 1;
    send_packet(1, 8);
    predict();
    wait_drain("s3_drain", 300, 1);
    tog_en = 0;

    // 4: constant change and enable drop during beat 2 of a 4-beat packet
    const_a[0] = 5;
    base = acc_cnt[0];
    send_packet(0, 4);
    predict();
    send_packet(0, 4);
    wait_acc("s4_beat2", 0, base + 1, 100);
    const_a[0] = 9;
    en_a[0] = 1'b0;
    wait_drain("s4_drain", 200, 0);
    repeat (10) @(posedge clk);
    #2;
    chk("s4_not_regranted_busy", 128'(status_busy), 128'(0));
    chk("s4_not_regranted_tready", 128'(s_ready), 128'(0));
    chk("s4_accepted", 128'(acc_cnt[0] - base), 128'(4));
    en_a[0] = 1'b1;
    predict();
    wait_drain("s4_drain2", 200, 1);

    // 5: reset on beat 3 of a 6-beat packet
    for (int i = 0; i < NREQ; i++) const_a[i] = $urandom;
    base = acc_cnt[0];
    send_packet(0, 6);
    predict();
    wait_acc("s5_beat3", 0, base + 2, 100);
    rst = 1;
    #1;
    chk("s5_m_valid", 128'(m_valid), 128'(0));
    chk("s5_busy", 128'(status_busy), 128'(0));
    chk("s5_grant", 128'(status_grant), 128'(0));
    chk("s5_tready", 128'(s_ready), 128'(0));
    flush_bench();
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    @(posedge clk);
    #2;
    send_packet(2, 2);
    send_packet(1, 2);
    send_packet(0, 2);
    chk("s5_first_pick", 128'(mptr), 128'(NREQ - 1));
    predict();
    wait_drain("s5_drain", 200, 1);

    // 6: single-beat packets from requesters 3 and 0
    for (int p = 0; p < 3; p++) begin
      send_packet(3, 1);
      send_packet(0, 1);
    end
    predict();
    wait_drain("s6_drain", 200, 1);

    // 7: random packets with random backpressure and mid-packet valid drops
    rnd_bp = 1;
    rnd_hold = 1;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < NREQ; i++) const_a[i] = $urandom;
      for (int i = 0; i < NREQ; i++)
        for (int p = $urandom_range(0, 3); p > 0; p--) send_packet(i, $urandom_range(1, 6));
      predict();
      wait_drain("s7_drain", 1500, 1);
    end
    rnd_bp = 0;
    rnd_hold = 0;

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
